// File: rtl/qos_pop_arbiter.sv
// Weighted round-robin pop arbiter for four QoS class FIFOs.
// Credits reload from INIT-sampled weights; grants stall on downstream almost-full.
module qos_pop_arbiter #(
  parameter int CREDIT_W = 3
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  init,
  input  logic [4*CREDIT_W-1:0] weights,
  input  logic [3:0]            fifo_empty,
  input  logic                  out_almost_full,
  output logic [3:0]            pop,
  output logic                  valid_out,
  output logic [1:0]            class_out,
  output logic                  idle,
  output logic [1:0]            state
);

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] weight_q [4];
  logic [CREDIT_W-1:0] weight_d [4];
  logic [CREDIT_W-1:0] credit_q [4];
  logic [CREDIT_W-1:0] credit_d [4];
  logic [1:0]          ptr_q, ptr_d;
  logic                valid_q, valid_d;
  logic [1:0]          class_q, class_d;

  logic [3:0]          pending;
  logic [3:0]          eligible;
  logic                grant_found;
  logic [1:0]          grant_idx;
  logic [1:0]          cand;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      pending[i]  = !fifo_empty[i] && (weight_q[i] != '0);
      eligible[i] = pending[i] && (credit_q[i] != '0);
    end
  end

  // First eligible class starting at ptr, wrapping mod 4.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = ptr_q;
    cand        = ptr_q;
    for (int k = 0; k < 4; k++) begin
      cand = ptr_q + k[1:0];
      if (!grant_found && eligible[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Handshake: pop[g] is a one-cycle combinational dequeue strobe to FIFO g;
  // valid_out/class_out are its registered image one cycle later, with no
  // back-pressure other than out_almost_full, which suppresses pop entirely.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    pop     = '0;
    for (int i = 0; i < 4; i++) begin
      weight_d[i] = weight_q[i];
      credit_d[i] = credit_q[i];
    end
    if (init) state_d = ST_INIT;

    unique case (state_q)
      ST_INIT: begin
        for (int i = 0; i < 4; i++) begin
          weight_d[i] = weights[i*CREDIT_W +: CREDIT_W];
        end
        if (!init) begin
          state_d = ST_IDLE;
          for (int i = 0; i < 4; i++) begin
            credit_d[i] = weight_d[i];
          end
        end
      end
      ST_IDLE: begin
        if (!init && (|pending)) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (!init) begin
          if (!(|pending)) begin
            state_d = ST_IDLE;
          end else if (!out_almost_full) begin
            if (grant_found) begin
              pop[grant_idx]      = 1'b1;
              credit_d[grant_idx] = credit_q[grant_idx] - CREDIT_W'(1);
              // Stay on the granted class until its credit runs out.
              ptr_d = (credit_q[grant_idx] == CREDIT_W'(1)) ? grant_idx + 2'd1 : grant_idx;
            end else begin
              for (int i = 0; i < 4; i++) begin
                credit_d[i] = weight_q[i];
              end
            end
          end
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_comb begin
    valid_d = |pop;
    class_d = 2'd0;
    unique case (pop)
      4'b0010: class_d = 2'd1;
      4'b0100: class_d = 2'd2;
      4'b1000: class_d = 2'd3;
      default: class_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= ST_INIT;
      ptr_q   <= '0;
      valid_q <= 1'b0;
      class_q <= '0;
      for (int i = 0; i < 4; i++) begin
        weight_q[i] <= '0;
        credit_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      class_q <= class_d;
      for (int i = 0; i < 4; i++) begin
        weight_q[i] <= weight_d[i];
        credit_q[i] <= credit_d[i];
      end
    end
  end

  assign valid_out = valid_q;
  assign class_out = class_q;
  assign idle      = (state_q == ST_IDLE);
  assign state     = state_q;

endmodule

// File: tb/tb_qos_pop_arbiter.sv
// Directed bench for qos_pop_arbiter: hand-computed pop sequences per cycle,
// with the registered valid/class tag checked against an expected queue.
module tb_qos_pop_arbiter;

  localparam int CREDIT_W = 3;

  logic                  clk = 1'b0;
  logic                  reset_L;
  logic                  init;
  logic [4*CREDIT_W-1:0] weights;
  logic [3:0]            fifo_empty;
  logic                  out_almost_full;
  logic [3:0]            pop;
  logic                  valid_out;
  logic [1:0]            class_out;
  logic                  idle;
  logic [1:0]            state;

  int checks = 0;
  int errors = 0;
  logic [2:0] exp_q[$];

  always #5 clk = ~clk;

  qos_pop_arbiter #(.CREDIT_W(CREDIT_W)) dut (
    .clk             (clk),
    .reset_L         (reset_L),
    .init            (init),
    .weights         (weights),
    .fifo_empty      (fifo_empty),
    .out_almost_full (out_almost_full),
    .pop             (pop),
    .valid_out       (valid_out),
    .class_out       (class_out),
    .idle            (idle),
    .state           (state)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] enc(input logic [3:0] p);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (p[i]) r = i[1:0];
    return r;
  endfunction

  // Called #1 after a rising edge with inputs already driven for this cycle.
  task automatic tick(input string tag, input logic [3:0] exp_pop);
    logic [2:0] e;
    #1;
    check_eq({tag, "_pop"}, {28'd0, pop}, {28'd0, exp_pop});
    exp_q.push_back({|exp_pop, enc(exp_pop)});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_eq({tag, "_valid"}, {31'd0, valid_out}, {31'd0, e[2]});
    if (e[2]) check_eq({tag, "_class"}, {30'd0, class_out}, {30'd0, e[1:0]});
  endtask

  initial begin
    reset_L         = 1'b0;
    init            = 1'b0;
    weights         = '0;
    fifo_empty      = 4'hF;
    out_almost_full = 1'b0;

    // Reset values
    #2;
    check_eq("rst_state", {30'd0, state}, 32'd0);
    check_eq("rst_pop", {28'd0, pop}, 32'd0);
    check_eq("rst_valid", {31'd0, valid_out}, 32'd0);
    check_eq("rst_class", {30'd0, class_out}, 32'd0);
    check_eq("rst_idle", {31'd0, idle}, 32'd0);
    @(posedge clk); #1;
    reset_L = 1'b1;

    // Init with weights {3,2,1,1}, all FIFOs empty
    init    = 1'b1;
    weights = {3'd3, 3'd2, 3'd1, 3'd1};
    tick("init0", 4'b0000);
    tick("init1", 4'b0000);
    check_eq("init_state", {30'd0, state}, 32'd0);
    init = 1'b0;
    tick("init_exit", 4'b0000);
    check_eq("idle_state", {30'd0, state}, 32'd1);
    check_eq("idle_flag", {31'd0, idle}, 32'd1);
    tick("idle_hold", 4'b0000);
    check_eq("idle_hold_state", {30'd0, state}, 32'd1);

    // WRR order with c0=2, c1=1, c2=1, c3=0
    init    = 1'b1;
    weights = {3'd0, 3'd1, 3'd1, 3'd2};
    tick("wrr_init", 4'b0000);
    init = 1'b0;
    tick("wrr_exit", 4'b0000);
    weights    = '1;
    fifo_empty = 4'b0000;
    check_eq("wrr_idle", {31'd0, idle}, 32'd1);
    tick("wrr_leave_idle", 4'b0000);
    check_eq("wrr_active", {30'd0, state}, 32'd2);
    for (int r = 0; r < 2; r++) begin
      tick("wrr_c0a", 4'b0001);
      tick("wrr_c0b", 4'b0001);
      tick("wrr_c1", 4'b0010);
      tick("wrr_c2", 4'b0100);
      tick("wrr_reload", 4'b0000);
    end

    // Empty skip: c0 drains while still holding one credit
    tick("skip_c0", 4'b0001);
    fifo_empty = 4'b0001;
    tick("skip_c1", 4'b0010);
    tick("skip_c2", 4'b0100);
    tick("skip_reload", 4'b0000);
    tick("skip_c1b", 4'b0010);
    tick("skip_c2b", 4'b0100);

    // Stall mid-round, then stall across a due reload
    fifo_empty = 4'b0000;
    tick("stall_pre_c0", 4'b0001);
    out_almost_full = 1'b1;
    tick("stall_a0", 4'b0000);
    tick("stall_a1", 4'b0000);
    tick("stall_a2", 4'b0000);
    out_almost_full = 1'b0;
    tick("stall_resume_c0", 4'b0001);
    out_almost_full = 1'b1;
    tick("stall_b0", 4'b0000);
    tick("stall_b1", 4'b0000);
    check_eq("stall_state", {30'd0, state}, 32'd2);
    out_almost_full = 1'b0;
    tick("stall_reload", 4'b0000);
    tick("post_c1", 4'b0010);
    tick("post_c2", 4'b0100);
    tick("post_c0", 4'b0001);

    // init mid-burst, new weights c0=1, c1=3, c2=0, c3=1
    init    = 1'b1;
    weights = {3'd1, 3'd0, 3'd3, 3'd1};
    tick("reinit0", 4'b0000);
    tick("reinit1", 4'b0000);
    check_eq("reinit_state", {30'd0, state}, 32'd0);
    init = 1'b0;
    tick("reinit_exit", 4'b0000);
    check_eq("reinit_idle", {31'd0, idle}, 32'd1);
    tick("reinit_leave", 4'b0000);
    tick("new_c0", 4'b0001);
    tick("new_c1a", 4'b0010);
    tick("new_c1b", 4'b0010);
    tick("new_c1c", 4'b0010);
    tick("new_c3", 4'b1000);
    tick("new_reload", 4'b0000);
    tick("new_c0b", 4'b0001);

    // Async reset while pop=0010, between edges
    #1;
    check_eq("pre_rst_pop", {28'd0, pop}, 32'h2);
    check_eq("pre_rst_valid", {31'd0, valid_out}, 32'd1);
    #1;
    reset_L = 1'b0;
    #1;
    check_eq("arst_pop", {28'd0, pop}, 32'd0);
    check_eq("arst_valid", {31'd0, valid_out}, 32'd0);
    check_eq("arst_idle", {31'd0, idle}, 32'd0);
    check_eq("arst_state", {30'd0, state}, 32'd0);
    check_eq("arst_class", {30'd0, class_out}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
